// File: rtl/pll_reset_seq_if.sv
// pll_reset_seq_if: bundles the PLL lock input and the sequencer's status/reset
// outputs so the controller and its consumer share one connection point.
interface pll_reset_seq_if;
  logic       pll_locked;
  logic       pll_stdy_rst;
  logic       sys_rst;
  logic       ready;
  logic [1:0] state;
  logic [7:0] timeout_cnt;
  logic [7:0] relock_cnt;
  logic       status_led;

  // The side that owns the PLL lock signal and observes the sequencer
  modport master (
    output pll_locked,
    input  pll_stdy_rst, sys_rst, ready, state, timeout_cnt, relock_cnt, status_led
  );

  // The sequencer itself
  modport slave (
    input  pll_locked,
    output pll_stdy_rst, sys_rst, ready, state, timeout_cnt, relock_cnt, status_led
  );
endinterface

// File: rtl/pll_reset_seq.sv
// pll_reset_seq: pulses the CC_PLL steady-state reset, waits for lock, qualifies it
// over a settle window and then releases the synchronous system reset. A lock loss
// in RUN restarts the whole sequence. Lock timeouts and relocks are counted.
// Optional feature macro: STATUS_LED_EN (blinking status LED driven by a 24-bit
// free-running counter); when undefined status_led is a registered copy of ready.
module pll_reset_seq #(
  parameter int SYNC_STAGES     = 2,
  parameter int STDY_RST_CYCLES = 4,
  parameter int SETTLE_CYCLES   = 16,
  parameter int LOCK_TIMEOUT    = 1024
`ifdef STATUS_LED_EN
  ,
  parameter int BLINK_BIT       = 3
`endif
) (
  input  logic              clk,
  input  logic              rst,
  pll_reset_seq_if.slave    if_pll
);

  localparam int CNT_W = $clog2(LOCK_TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] STDY_LAST    = CNT_W'(STDY_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_STDYRST = 2'd0,
    ST_WAIT    = 2'd1,
    ST_SETTLE  = 2'd2,
    ST_RUN     = 2'd3
  } state_t;

  state_t                 r_state;
  state_t                 w_nextState;
  logic [CNT_W-1:0]       r_cnt;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_lockedS;
  logic                   w_timeoutInc;
  logic                   w_relockInc;
  logic                   r_pllStdyRst;
  logic                   r_sysRst;
  logic                   r_ready;
  logic [7:0]             r_timeoutCnt;
  logic [7:0]             r_relockCnt;
  logic                   r_statusLed;

  // Bring the asynchronous PLL lock flag into the clk domain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_sync <= '0;
    else     r_sync <= {r_sync[SYNC_STAGES-2:0], if_pll.pll_locked};
  end

  assign w_lockedS = r_sync[SYNC_STAGES-1];

  // Next-state decision; lock takes priority over timeout while waiting
  always_comb begin
    w_nextState  = r_state;
    w_timeoutInc = 1'b0;
    w_relockInc  = 1'b0;
    case (r_state)
      ST_STDYRST: begin
        if (r_cnt == STDY_LAST) w_nextState = ST_WAIT;
      end
      ST_WAIT: begin
        if (w_lockedS) begin
          w_nextState = ST_SETTLE;
        end else if (r_cnt == TIMEOUT_LAST) begin
          w_nextState  = ST_STDYRST;
          w_timeoutInc = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (!w_lockedS)                w_nextState = ST_WAIT;
        else if (r_cnt == SETTLE_LAST) w_nextState = ST_RUN;
      end
      ST_RUN: begin
        if (!w_lockedS) begin
          w_nextState = ST_STDYRST;
          w_relockInc = 1'b1;
        end
      end
      default: w_nextState = ST_STDYRST;
    endcase
  end

  // State register and the shared cycle counter, cleared on every state change
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_STDYRST;
      r_cnt   <= '0;
    end else begin
      r_state <= w_nextState;
      if (w_nextState != r_state) r_cnt <= '0;
      else                        r_cnt <= r_cnt + 1'b1;
    end
  end

  // Outputs are registered from the next state so they change together with state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pllStdyRst <= 1'b1;
      r_sysRst     <= 1'b1;
      r_ready      <= 1'b0;
    end else begin
      r_pllStdyRst <= (w_nextState == ST_STDYRST);
      r_sysRst     <= (w_nextState != ST_RUN);
      r_ready      <= (w_nextState == ST_RUN);
    end
  end

  // Saturating event counters for lock timeouts and lock losses in RUN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_timeoutCnt <= '0;
      r_relockCnt  <= '0;
    end else begin
      if (w_timeoutInc && (r_timeoutCnt != 8'hFF)) r_timeoutCnt <= r_timeoutCnt + 8'd1;
      if (w_relockInc && (r_relockCnt != 8'hFF))   r_relockCnt  <= r_relockCnt + 8'd1;
    end
  end

`ifdef STATUS_LED_EN
  logic [23:0] r_blink;

  // Free-running blink counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_blink <= '0;
    else     r_blink <= r_blink + 24'd1;
  end

  // LED off while the PLL is held in reset, blinking while locking, solid in RUN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_statusLed <= 1'b0;
    end else begin
      case (w_nextState)
        ST_STDYRST: r_statusLed <= 1'b0;
        ST_RUN:     r_statusLed <= 1'b1;
        default:    r_statusLed <= r_blink[BLINK_BIT];
      endcase
    end
  end
`else
  // LED simply follows ready one cycle later
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_statusLed <= 1'b0;
    else     r_statusLed <= r_ready;
  end
`endif

  assign if_pll.pll_stdy_rst = r_pllStdyRst;
  assign if_pll.sys_rst      = r_sysRst;
  assign if_pll.ready        = r_ready;
  assign if_pll.state        = r_state;
  assign if_pll.timeout_cnt  = r_timeoutCnt;
  assign if_pll.relock_cnt   = r_relockCnt;
  assign if_pll.status_led   = r_statusLed;

endmodule

// File: tb/tb_pll_reset_seq.sv
// tb_pll_reset_seq: directed bench for pll_reset_seq with default parameters.
// Edge numbering in comments: edge 0 is the first rising clk edge after rst falls.
module tb_pll_reset_seq;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  pll_reset_seq_if bus();

  pll_reset_seq dut (
    .clk    (clk),
    .rst    (rst),
    .if_pll (bus)
  );

  // 10-unit clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case the sequence never finishes
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  // One comparison point: counts it, and counts and reports any difference
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Drive pll_locked and advance the given number of rising edges, ending 1 unit after the last
  task automatic applyStimulus(input logic locked, input int cycles);
    bus.pll_locked = locked;
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Pulse rst for two edges; the next rising edge after return is edge 0
  task automatic applyReset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Advance until state reaches the target or the budget runs out, then compare
  task automatic waitState(input string tag, input logic [1:0] target, input int limit);
    int n = 0;
    while ((bus.state !== target) && (n < limit)) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput(tag, 32'(bus.state), 32'(target));
  endtask

  // Directed sequence
  initial begin
    vectors        = 0;
    miscompares    = 0;
    rst            = 1'b1;
    bus.pll_locked = 1'b0;

    // Reset values, sampled mid-cycle
    #23;
    checkOutput("rst_state",   32'(bus.state),        32'd0);
    checkOutput("rst_stdy",    32'(bus.pll_stdy_rst), 32'd1);
    checkOutput("rst_sysrst",  32'(bus.sys_rst),      32'd1);
    checkOutput("rst_ready",   32'(bus.ready),        32'd0);
    checkOutput("rst_timeout", 32'(bus.timeout_cnt),  32'd0);
    checkOutput("rst_relock",  32'(bus.relock_cnt),   32'd0);
    checkOutput("rst_led",     32'(bus.status_led),   32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // No lock at all: stdy pulse, 1024-cycle wait, repeated timeouts
    applyStimulus(1'b0, 3);                              // edges 0..2
    checkOutput("t1_stdy_hold_state", 32'(bus.state),        32'd0);
    checkOutput("t1_stdy_hold",       32'(bus.pll_stdy_rst), 32'd1);
    applyStimulus(1'b0, 1);                              // edge 3
    checkOutput("t1_wait_state",      32'(bus.state),        32'd1);
    checkOutput("t1_stdy_low",        32'(bus.pll_stdy_rst), 32'd0);
    applyStimulus(1'b0, 1023);                           // edges 4..1026
    checkOutput("t1_pre_timeout_state", 32'(bus.state),       32'd1);
    checkOutput("t1_pre_timeout_cnt",   32'(bus.timeout_cnt), 32'd0);
    applyStimulus(1'b0, 1);                              // edge 1027
    checkOutput("t1_timeout1_state",  32'(bus.state),        32'd0);
    checkOutput("t1_timeout1_stdy",   32'(bus.pll_stdy_rst), 32'd1);
    checkOutput("t1_timeout1_cnt",    32'(bus.timeout_cnt),  32'd1);
    applyStimulus(1'b0, 1027);                           // edges 1028..2054
    checkOutput("t1_wait2_state",     32'(bus.state),        32'd1);
    checkOutput("t1_wait2_sysrst",    32'(bus.sys_rst),      32'd1);
    applyStimulus(1'b0, 1);                              // edge 2055
    checkOutput("t1_timeout2_state",  32'(bus.state),        32'd0);
    checkOutput("t1_timeout2_cnt",    32'(bus.timeout_cnt),  32'd2);

    // Lock seen on the very edge the timeout would fire: lock wins
    bus.pll_locked = 1'b0;
    applyReset();
    checkOutput("tc_reset_timeout", 32'(bus.timeout_cnt), 32'd0);
    applyStimulus(1'b0, 1025);                           // edges 0..1024
    applyStimulus(1'b1, 2);                              // edges 1025..1026, locked_s rises
    checkOutput("tc_still_wait", 32'(bus.state), 32'd1);
    applyStimulus(1'b1, 1);                              // edge 1027
    checkOutput("tc_lock_wins_state", 32'(bus.state),       32'd2);
    checkOutput("tc_lock_wins_cnt",   32'(bus.timeout_cnt), 32'd0);

    // Lock lost during SETTLE, then full settle window on re-lock
    bus.pll_locked = 1'b0;
    applyReset();
    applyStimulus(1'b0, 4);                              // edges 0..3
    applyStimulus(1'b1, 8);                              // edges 4..11
    checkOutput("t3_settle", 32'(bus.state), 32'd2);
    applyStimulus(1'b0, 2);                              // edges 12..13
    checkOutput("t3_settle_hold", 32'(bus.state), 32'd2);
    applyStimulus(1'b0, 1);                              // edge 14
    checkOutput("t3_back_wait",    32'(bus.state),       32'd1);
    checkOutput("t3_sysrst",       32'(bus.sys_rst),     32'd1);
    checkOutput("t3_timeout_same", 32'(bus.timeout_cnt), 32'd0);
    checkOutput("t3_relock_same",  32'(bus.relock_cnt),  32'd0);
    applyStimulus(1'b1, 18);                             // edges 15..32
    checkOutput("t3_resettle_state",  32'(bus.state),   32'd2);
    checkOutput("t3_resettle_sysrst", 32'(bus.sys_rst), 32'd1);
    applyStimulus(1'b1, 1);                              // edge 33
    checkOutput("t3_run_state",  32'(bus.state),   32'd3);
    checkOutput("t3_run_sysrst", 32'(bus.sys_rst), 32'd0);

    // Clean lock: 19 edges from raw lock to sys_rst release
    bus.pll_locked = 1'b0;
    applyReset();
    applyStimulus(1'b0, 4);                              // edges 0..3
    applyStimulus(1'b1, 4);                              // edges 4..7
    checkOutput("t2_settle", 32'(bus.state), 32'd2);
`ifdef STATUS_LED_EN
    checkOutput("t6_blink_lo", 32'(bus.status_led), 32'd0);
`endif
    applyStimulus(1'b1, 1);                              // edge 8
`ifdef STATUS_LED_EN
    checkOutput("t6_blink_hi", 32'(bus.status_led), 32'd1);
`else
    checkOutput("t6_led_off", 32'(bus.status_led), 32'd0);
`endif
    applyStimulus(1'b1, 13);                             // edges 9..21
    checkOutput("t2_edge18_sysrst", 32'(bus.sys_rst), 32'd1);
    checkOutput("t2_edge18_state",  32'(bus.state),   32'd2);
    applyStimulus(1'b1, 1);                              // edge 22
    checkOutput("t2_release_sysrst", 32'(bus.sys_rst),      32'd0);
    checkOutput("t2_release_ready",  32'(bus.ready),        32'd1);
    checkOutput("t2_release_state",  32'(bus.state),        32'd3);
    checkOutput("t2_release_relock", 32'(bus.relock_cnt),   32'd0);
    checkOutput("t2_release_stdy",   32'(bus.pll_stdy_rst), 32'd0);
`ifdef STATUS_LED_EN
    checkOutput("t6_led_run", 32'(bus.status_led), 32'd1);
`else
    checkOutput("t6_led_lag", 32'(bus.status_led), 32'd0);
`endif
    applyStimulus(1'b1, 1);                              // edge 23
    checkOutput("t6_led_on", 32'(bus.status_led), 32'd1);

    // One-cycle lock drop in RUN
    applyStimulus(1'b0, 1);                              // edge 24
    applyStimulus(1'b1, 1);                              // edge 25, locked_s now low
    checkOutput("t4_pre_loss_state",  32'(bus.state),   32'd3);
    checkOutput("t4_pre_loss_sysrst", 32'(bus.sys_rst), 32'd0);
    applyStimulus(1'b1, 1);                              // edge 26
    checkOutput("t4_loss_state",  32'(bus.state),        32'd0);
    checkOutput("t4_loss_sysrst", 32'(bus.sys_rst),      32'd1);
    checkOutput("t4_loss_stdy",   32'(bus.pll_stdy_rst), 32'd1);
    checkOutput("t4_loss_ready",  32'(bus.ready),        32'd0);
    checkOutput("t4_loss_relock", 32'(bus.relock_cnt),   32'd1);
    applyStimulus(1'b1, 20);                             // edges 27..46
    checkOutput("t4_resettle", 32'(bus.state), 32'd2);
    applyStimulus(1'b1, 1);                              // edge 47
    checkOutput("t4_rerun", 32'(bus.state), 32'd3);

    // 299 more losses: relock_cnt must saturate at 255
    for (int i = 0; i < 299; i++) begin
      applyStimulus(1'b0, 1);
      bus.pll_locked = 1'b1;
      waitState("t4_loop_restart", 2'd0, 10);
      if (i == 0) checkOutput("t4_relock_two", 32'(bus.relock_cnt), 32'd2);
      waitState("t4_loop_run", 2'd3, 100);
    end
    checkOutput("t4_relock_sat",   32'(bus.relock_cnt),  32'd255);
    checkOutput("t4_timeout_zero", 32'(bus.timeout_cnt), 32'd0);

    // Asynchronous reset mid-SETTLE, between edges
    applyStimulus(1'b0, 1);
    bus.pll_locked = 1'b1;
    waitState("t5_reach_settle", 2'd2, 40);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("t5_async_state",  32'(bus.state),        32'd0);
    checkOutput("t5_async_stdy",   32'(bus.pll_stdy_rst), 32'd1);
    checkOutput("t5_async_sysrst", 32'(bus.sys_rst),      32'd1);
    checkOutput("t5_async_ready",  32'(bus.ready),        32'd0);
    checkOutput("t5_async_relock", 32'(bus.relock_cnt),   32'd0);
    checkOutput("t5_async_led",    32'(bus.status_led),   32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus(1'b1, 3);                              // edges 0..2
    checkOutput("t5_restart_state", 32'(bus.state),        32'd0);
    checkOutput("t5_restart_stdy",  32'(bus.pll_stdy_rst), 32'd1);
    applyStimulus(1'b1, 1);                              // edge 3
    checkOutput("t5_restart_wait", 32'(bus.state), 32'd1);
    applyStimulus(1'b1, 1);                              // edge 4
    checkOutput("t5_restart_settle", 32'(bus.state), 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
